// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo
//   Decouples the DDC I/Q sample rate from the I2S frame rate. Samples are
//   queued as they arrive. One I/Q pair is released per LRCLK rising edge.
//   The output pair is held stable between releases so the I2S side can pick
//   it up through its own synchroniser.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_PRIME| filling; frame ticks ignored, outputs hold last sample
//   ST_RUN  | one pop per frame tick; empty at a tick -> underflow, re-prime
//
// Ports
//   SAICLK                  audio master clock, all logic on posedge
//   reset                   synchronous, active-low
//   i_flush                 synchronous clear of FIFO contents
//   i_in_valid              one-cycle strobe qualifying i_in_real/i_in_imag
//   i_in_real, i_in_imag    DDC I/Q sample, two's complement
//   i_lrclk                 I2S word clock, asynchronous to SAICLK
//   o_out_real, o_out_imag  sample pair to the I2S transmitter
//   o_out_strobe            one-cycle pulse when o_out_* update
//   o_level                 occupancy, 0..2**AW
//   o_running               high in ST_RUN
//   o_ovf_cnt, o_unf_cnt    saturating drop / underflow event counters
module rx_frame_fifo #(
    parameter int DW        = 24,
    parameter int AW        = 4,
    parameter int PRIME_LVL = 8
) (
    input  logic          SAICLK,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_in_valid,
    input  logic [DW-1:0] i_in_real,
    input  logic [DW-1:0] i_in_imag,
    input  logic          i_lrclk,
    output logic [DW-1:0] o_out_real,
    output logic [DW-1:0] o_out_imag,
    output logic          o_out_strobe,
    output logic [AW:0]   o_level,
    output logic          o_running,
    output logic [7:0]    o_ovf_cnt,
    output logic [7:0]    o_unf_cnt
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_L = (AW+1)'(PRIME_LVL);

    typedef enum logic {ST_PRIME, ST_RUN} state_t;

    state_t          r_state;
    logic [2*DW-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [DW-1:0]   r_out_real;
    logic [DW-1:0]   r_out_imag;
    logic            r_out_strobe;
    logic [7:0]      r_ovf_cnt;
    logic [7:0]      r_unf_cnt;

    logic            r_lr_meta;
    logic            r_lr_sync;
    logic            r_lr_dly;
    logic            r_tick;

    logic            w_run_tick;
    logic            w_pop;
    logic            w_unf;
    logic            w_push;
    logic            w_ovf;

    // The tick is registered so that an LRCLK pin edge reaches the FSM
    // three SAICLK cycles later.
    always_ff @(posedge SAICLK) begin
        if (!reset) begin
            r_lr_meta <= 1'b0;
            r_lr_sync <= 1'b0;
            r_lr_dly  <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_lr_meta <= i_lrclk;
            r_lr_sync <= r_lr_meta;
            r_lr_dly  <= r_lr_sync;
            r_tick    <= r_lr_sync & ~r_lr_dly;
        end
    end

    // Underflow is judged on the registered level, before any same-cycle push.
    // At full, a push is accepted when a pop happens in the same cycle.
    assign w_run_tick = (r_state == ST_RUN) && r_tick && !i_flush;
    assign w_pop      = w_run_tick && (r_level != '0);
    assign w_unf      = w_run_tick && (r_level == '0);
    assign w_push     = i_in_valid && !i_flush && ((r_level != FULL) || w_pop);
    assign w_ovf      = i_in_valid && !i_flush && (r_level == FULL) && !w_pop;

    // When full, wr_ptr equals rd_ptr. A push+pop then reads the old entry
    // before it is overwritten.
    always_ff @(posedge SAICLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {i_in_real, i_in_imag};
    end

    always_ff @(posedge SAICLK) begin
        if (!reset) begin
            r_state      <= ST_PRIME;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_out_real   <= '0;
            r_out_imag   <= '0;
            r_out_strobe <= 1'b0;
            r_ovf_cnt    <= '0;
            r_unf_cnt    <= '0;
        end else begin
            r_out_strobe <= 1'b0;

            if (w_ovf && (r_ovf_cnt != 8'hFF))
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            if (w_unf && (r_unf_cnt != 8'hFF))
                r_unf_cnt <= r_unf_cnt + 8'd1;

            if (i_flush) begin
                r_state  <= ST_PRIME;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;

                if (w_pop) begin
                    r_rd_ptr     <= r_rd_ptr + 1'b1;
                    r_out_real   <= r_mem[r_rd_ptr][2*DW-1:DW];
                    r_out_imag   <= r_mem[r_rd_ptr][DW-1:0];
                    r_out_strobe <= 1'b1;
                end

                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + (AW+1)'(1);
                    2'b01:   r_level <= r_level - (AW+1)'(1);
                    default: r_level <= r_level;
                endcase

                case (r_state)
                    ST_PRIME: if (r_level >= PRIME_L) r_state <= ST_RUN;
                    ST_RUN:   if (w_unf)              r_state <= ST_PRIME;
                    default:                          r_state <= ST_PRIME;
                endcase
            end
        end
    end

    assign o_out_real   = r_out_real;
    assign o_out_imag   = r_out_imag;
    assign o_out_strobe = r_out_strobe;
    assign o_level      = r_level;
    assign o_running    = (r_state == ST_RUN);
    assign o_ovf_cnt    = r_ovf_cnt;
    assign o_unf_cnt    = r_unf_cnt;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb_rx_frame_fifo
//   Directed bench for rx_frame_fifo. Inputs change 1 time unit after the
//   SAICLK rising edge. Outputs are sampled at the same point.
//   A frame is 128 SAICLK: LRCLK is high for 64 cycles and low for 64 cycles.
module tb_rx_frame_fifo;

    logic        SAICLK = 1'b0;
    logic        reset;
    logic        i_flush;
    logic        i_in_valid;
    logic [23:0] i_in_real;
    logic [23:0] i_in_imag;
    logic        i_lrclk;
    logic [23:0] o_out_real;
    logic [23:0] o_out_imag;
    logic        o_out_strobe;
    logic [4:0]  o_level;
    logic        o_running;
    logic [7:0]  o_ovf_cnt;
    logic [7:0]  o_unf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 SAICLK = ~SAICLK;

    rx_frame_fifo #(.DW(24), .AW(4), .PRIME_LVL(8)) u_dut (
        .SAICLK       (SAICLK),
        .reset        (reset),
        .i_flush      (i_flush),
        .i_in_valid   (i_in_valid),
        .i_in_real    (i_in_real),
        .i_in_imag    (i_in_imag),
        .i_lrclk      (i_lrclk),
        .o_out_real   (o_out_real),
        .o_out_imag   (o_out_imag),
        .o_out_strobe (o_out_strobe),
        .o_level      (o_level),
        .o_running    (o_running),
        .o_ovf_cnt    (o_ovf_cnt),
        .o_unf_cnt    (o_unf_cnt)
    );

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge SAICLK);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        i_flush    = 1'b0;
        i_in_valid = 1'b0;
        i_in_real  = '0;
        i_in_imag  = '0;
        i_lrclk    = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
    endtask

    task automatic push(input int n);
        i_in_valid = 1'b1;
        i_in_real  = 24'(n);
        i_in_imag  = -24'(n);
        step(1);
        i_in_valid = 1'b0;
    endtask

    task automatic push_seq(input int first, input int count);
        for (int k = 0; k < count; k++)
            push(first + k);
    endtask

    // One LRCLK frame. The internal tick is high in the cycle after the 3rd
    // edge. A push driven then coincides with it. Outputs are checked after
    // the 4th edge.
    task automatic frame(input bit push_en, input int pv, input bit exp_stb,
                         input int ev, input string tag);
        logic [23:0] er;
        logic [23:0] ei;
        er = 24'(ev);
        ei = -er;
        i_lrclk = 1'b1;
        step(3);
        chk_val({tag, " strobe early"}, 32'(o_out_strobe), 32'(0));
        if (push_en) begin
            i_in_valid = 1'b1;
            i_in_real  = 24'(pv);
            i_in_imag  = -24'(pv);
        end
        step(1);
        i_in_valid = 1'b0;
        chk_val({tag, " strobe"}, 32'(o_out_strobe), 32'(exp_stb));
        chk_val({tag, " real"},   32'(o_out_real),   32'(er));
        chk_val({tag, " imag"},   32'(o_out_imag),   32'(ei));
        step(60);
        i_lrclk = 1'b0;
        step(64);
    endtask

    initial begin
        // reset values
        do_reset();
        chk_val("rst real",    32'(o_out_real),   32'(0));
        chk_val("rst imag",    32'(o_out_imag),   32'(0));
        chk_val("rst strobe",  32'(o_out_strobe), 32'(0));
        chk_val("rst level",   32'(o_level),      32'(0));
        chk_val("rst running", 32'(o_running),    32'(0));
        chk_val("rst ovf",     32'(o_ovf_cnt),    32'(0));
        chk_val("rst unf",     32'(o_unf_cnt),    32'(0));

        // 1: prime with 8, then in-order output at frame rate
        push_seq(1, 7);
        step(1);
        chk_val("t1 not running at 7", 32'(o_running), 32'(0));
        push(8);
        step(1);
        chk_val("t1 running at 8", 32'(o_running), 32'(1));
        chk_val("t1 level 8",      32'(o_level),   32'(8));
        for (int k = 1; k <= 3; k++)
            frame(1'b0, 0, 1'b1, k, $sformatf("t1 frame%0d", k));
        chk_val("t1 level 5", 32'(o_level), 32'(5));

        // 2: overflow while filling, then read back in order
        do_reset();
        push_seq(1, 20);
        chk_val("t2 level full", 32'(o_level),   32'(16));
        chk_val("t2 ovf 4",      32'(o_ovf_cnt), 32'(4));
        for (int k = 1; k <= 16; k++)
            frame(1'b0, 0, 1'b1, k, $sformatf("t2 frame%0d", k));
        chk_val("t2 level empty", 32'(o_level), 32'(0));

        // 3: underflow after 8 pops, then a tick in PRIME is ignored
        do_reset();
        push_seq(1, 8);
        step(1);
        for (int k = 1; k <= 8; k++)
            frame(1'b0, 0, 1'b1, k, $sformatf("t3 frame%0d", k));
        frame(1'b0, 0, 1'b0, 8, "t3 unf tick");
        chk_val("t3 unf 1",        32'(o_unf_cnt), 32'(1));
        chk_val("t3 stopped",      32'(o_running), 32'(0));
        frame(1'b0, 0, 1'b0, 8, "t3 idle tick");
        chk_val("t3 unf still 1",  32'(o_unf_cnt), 32'(1));
        chk_val("t3 still stopped", 32'(o_running), 32'(0));

        // 4: push and pop in the same cycle at full
        do_reset();
        push_seq(1, 16);
        chk_val("t4 running", 32'(o_running), 32'(1));
        frame(1'b1, 17, 1'b1, 1, "t4 full push+pop");
        chk_val("t4 ovf 0",   32'(o_ovf_cnt), 32'(0));
        chk_val("t4 level 16", 32'(o_level),  32'(16));
        for (int k = 2; k <= 17; k++)
            frame(1'b0, 0, 1'b1, k, $sformatf("t4 frame%0d", k));

        // 5: flush with a concurrent push
        do_reset();
        push_seq(1, 8);
        step(1);
        for (int k = 1; k <= 3; k++)
            frame(1'b0, 0, 1'b1, k, $sformatf("t5 frame%0d", k));
        chk_val("t5 level 5", 32'(o_level), 32'(5));
        i_flush    = 1'b1;
        i_in_valid = 1'b1;
        i_in_real  = 24'd99;
        i_in_imag  = -24'd99;
        step(1);
        i_flush    = 1'b0;
        i_in_valid = 1'b0;
        chk_val("t5 flush level",   32'(o_level),    32'(0));
        chk_val("t5 flush running", 32'(o_running),  32'(0));
        chk_val("t5 flush out",     32'(o_out_real), 32'(3));
        chk_val("t5 flush ovf",     32'(o_ovf_cnt),  32'(0));
        push_seq(100, 7);
        step(1);
        chk_val("t5 level 7",        32'(o_level),   32'(7));
        chk_val("t5 not primed at 7", 32'(o_running), 32'(0));
        push(107);
        step(1);
        chk_val("t5 reprimed", 32'(o_running), 32'(1));
        frame(1'b0, 0, 1'b1, 100, "t5 first after flush");

        // 6: reset mid-frame with non-zero state, then wrap the pointers
        do_reset();
        push_seq(1, 8);
        step(1);
        for (int k = 1; k <= 8; k++)
            frame(1'b0, 0, 1'b1, k, $sformatf("t6 drain%0d", k));
        frame(1'b0, 0, 1'b0, 8, "t6 unf tick");
        push_seq(9, 18);
        for (int k = 9; k <= 12; k++)
            frame(1'b0, 0, 1'b1, k, $sformatf("t6 frame%0d", k));
        chk_val("t6 pre level 12", 32'(o_level),   32'(12));
        chk_val("t6 pre ovf 2",    32'(o_ovf_cnt), 32'(2));
        chk_val("t6 pre unf 1",    32'(o_unf_cnt), 32'(1));
        i_lrclk = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        chk_val("t6 rst real",    32'(o_out_real),   32'(0));
        chk_val("t6 rst imag",    32'(o_out_imag),   32'(0));
        chk_val("t6 rst strobe",  32'(o_out_strobe), 32'(0));
        chk_val("t6 rst level",   32'(o_level),      32'(0));
        chk_val("t6 rst running", 32'(o_running),    32'(0));
        chk_val("t6 rst ovf",     32'(o_ovf_cnt),    32'(0));
        chk_val("t6 rst unf",     32'(o_unf_cnt),    32'(0));
        i_lrclk = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        push_seq(1, 8);
        step(1);
        for (int k = 0; k < 40; k++)
            frame(1'b1, 9 + k, 1'b1, k + 1, $sformatf("t6 wrap%0d", k));
        chk_val("t6 wrap level", 32'(o_level),   32'(8));
        chk_val("t6 wrap ovf",   32'(o_ovf_cnt), 32'(0));
        chk_val("t6 wrap unf",   32'(o_unf_cnt), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
